// File: rtl/inst_decode_stage.sv
// Pipelined instruction-decode stage: extracts register/enable fields into one output
// register behind a valid/ready handshake, with a RAW scoreboard that stalls fetch.
module inst_decode_stage #(
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned RA_W       = 3,
  parameter int unsigned WMEM_BIT   = 15,
  parameter int unsigned WREG_BIT   = 14,
  parameter int unsigned R0_LSB     = 11,
  parameter int unsigned R1_LSB     = 8,
  parameter int unsigned WD_LSB     = 5,
  parameter int unsigned HAZ_DEPTH  = 3,
  parameter bit          R0_IS_ZERO = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_WIDTH-1:0] inst_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RA_W-1:0]       r0addr_out,
  output logic [RA_W-1:0]       r1addr_out,
  output logic                  WRegEn_out,
  output logic                  WMemEn_out,
  output logic [RA_W-1:0]       WReg1_out,
  output logic                  hazard_out
);

  logic                  out_valid_q;
  logic [RA_W-1:0]       r0_q, r1_q, wd_q;
  logic                  wreg_en_q, wmem_en_q;

  // Writes issued downstream but not yet written back; index 0 is the youngest.
  logic [HAZ_DEPTH-1:0]           hist_wen_q;
  logic [HAZ_DEPTH-1:0][RA_W-1:0] hist_addr_q;

  logic [RA_W-1:0] src0, src1;
  logic            hit0, hit1;
  logic            acc, iss;

  assign src0 = inst_in[R0_LSB +: RA_W];
  assign src1 = inst_in[R1_LSB +: RA_W];

  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    if (out_valid_q && wreg_en_q) begin
      hit0 = (wd_q == src0);
      hit1 = (wd_q == src1);
    end
    for (int k = 0; k < HAZ_DEPTH; k++) begin
      if (hist_wen_q[k]) begin
        hit0 = hit0 | (hist_addr_q[k] == src0);
        hit1 = hit1 | (hist_addr_q[k] == src1);
      end
    end
    if (R0_IS_ZERO) begin
      if (src0 == '0) hit0 = 1'b0;
      if (src1 == '0) hit1 = 1'b0;
    end
  end

  assign hazard_out = in_valid & (hit0 | hit1);

  // Flush also blocks intake so the cycle that discards the held instruction loads nothing.
  assign in_ready = en & ~flush & ~hazard_out & (~out_valid_q | out_ready);
  assign acc      = in_valid & in_ready;
  assign iss      = en & ~flush & out_valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      r0_q        <= '0;
      r1_q        <= '0;
      wd_q        <= '0;
      wreg_en_q   <= 1'b0;
      wmem_en_q   <= 1'b0;
      hist_wen_q  <= '0;
      hist_addr_q <= '0;
    end else if (en) begin
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (acc) begin
        out_valid_q <= 1'b1;
        r0_q        <= src0;
        r1_q        <= src1;
        wd_q        <= inst_in[WD_LSB +: RA_W];
        wreg_en_q   <= inst_in[WREG_BIT];
        wmem_en_q   <= inst_in[WMEM_BIT];
      end else if (iss) begin
        out_valid_q <= 1'b0;
      end
      for (int k = HAZ_DEPTH - 1; k > 0; k--) begin
        hist_wen_q[k]  <= hist_wen_q[k-1];
        hist_addr_q[k] <= hist_addr_q[k-1];
      end
      hist_wen_q[0]  <= iss & wreg_en_q;
      hist_addr_q[0] <= wd_q;
    end
  end

  assign out_valid  = out_valid_q;
  assign r0addr_out = r0_q;
  assign r1addr_out = r1_q;
  assign WReg1_out  = wd_q;
  assign WRegEn_out = wreg_en_q;
  assign WMemEn_out = wmem_en_q;

  // Only the decoded fields of the instruction word are consumed.
  logic unused_inst;
  assign unused_inst = ^inst_in;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Directed bench for inst_decode_stage: decode, handshake, RAW stall, freeze, flush, reset.
module tb_inst_decode_stage;

  logic        clk = 1'b0;
  logic        reset, en, flush, in_valid, out_ready;
  logic        in_ready, out_valid, WRegEn_out, WMemEn_out, hazard_out;
  logic [31:0] inst_in;
  logic [2:0]  r0addr_out, r1addr_out, WReg1_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_decode_stage dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inst_in    (inst_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .r0addr_out (r0addr_out),
    .r1addr_out (r1addr_out),
    .WRegEn_out (WRegEn_out),
    .WMemEn_out (WMemEn_out),
    .WReg1_out  (WReg1_out),
    .hazard_out (hazard_out)
  );

  function automatic logic [31:0] mk(input logic wmem, input logic wreg, input logic [2:0] r0,
                                     input logic [2:0] r1, input logic [2:0] wd);
    mk = {16'h0, wmem, wreg, r0, r1, wd, 5'h0};
  endfunction

  // {out_valid, WMemEn, WRegEn, r0, r1, WReg1}
  function automatic logic [11:0] exp_out(input logic v, input logic [31:0] i);
    exp_out = {v, i[15], i[14], i[13:11], i[10:8], i[7:5]};
  endfunction

  logic [11:0] obs;
  assign obs = {out_valid, WMemEn_out, WRegEn_out, r0addr_out, r1addr_out, WReg1_out};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inst_in = '0;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== 12'h000) begin errors++; $display("FAIL reset_outputs: got %h want 000", obs); end
    checks++;
    if (hazard_out !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b want 0", hazard_out); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_decode();
    do_reset();
    inst_in = 32'h0000_C9A0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL decode_in_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 1'b1, 1'b1, 3'd1, 3'd1, 3'd5})
      begin errors++; $display("FAIL decode_fields: got %h want %h", obs, {1'b1, 1'b1, 1'b1, 3'd1, 3'd1, 3'd5}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    a = mk(1'b0, 1'b1, 3'd1, 3'd2, 3'd5);
    b = mk(1'b1, 1'b0, 3'd6, 3'd2, 3'd7);
    do_reset();
    out_ready = 1'b1; inst_in = a; in_valid = 1'b1;
    step();
    inst_in = b;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++;
    if (obs !== exp_out(1'b1, b)) begin errors++; $display("FAIL b2b_fields: got %h want %h", obs, exp_out(1'b1, b)); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    a = mk(1'b0, 1'b1, 3'd1, 3'd2, 3'd4);
    b = mk(1'b0, 1'b1, 3'd6, 3'd7, 3'd3);
    do_reset();
    inst_in = a; in_valid = 1'b1;
    step();
    inst_in = b;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      step();
      checks++;
      if (obs !== exp_out(1'b1, a)) begin errors++; $display("FAIL bp_stable[%0d]: got %h want %h", i, obs, exp_out(1'b1, a)); end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++;
    if (obs !== exp_out(1'b1, b)) begin errors++; $display("FAIL bp_first_fire: got %h want %h", obs, exp_out(1'b1, b)); end
  endtask

  // A writes r3 then B reads r3; optionally freeze en for cycles 3 and 4 of the stall.
  task automatic run_raw(input bit freeze, input int exp_hz, input int exp_b);
    int hz = 0, nrdy = 0, b_at = 0;
    do_reset();
    out_ready = 1'b1; inst_in = mk(1'b0, 1'b1, 3'd1, 3'd2, 3'd3); in_valid = 1'b1;
    step();
    inst_in = mk(1'b0, 1'b1, 3'd3, 3'd0, 3'd6);
    for (int i = 1; i <= 12; i++) begin
      en = (freeze && (i == 3 || i == 4)) ? 1'b0 : 1'b1;
      #1;
      if (hazard_out) hz++;
      if (!in_ready) nrdy++;
      step();
      if (out_valid && WReg1_out == 3'd6 && b_at == 0) b_at = i;
    end
    en = 1'b1; in_valid = 1'b0;
    checks++;
    if (hz != exp_hz) begin errors++; $display("FAIL raw_hazard_cycles(freeze=%0d): got %0d want %0d", freeze, hz, exp_hz); end
    checks++;
    if (nrdy != exp_hz) begin errors++; $display("FAIL raw_stall_cycles(freeze=%0d): got %0d want %0d", freeze, nrdy, exp_hz); end
    checks++;
    if (b_at != exp_b) begin errors++; $display("FAIL raw_b_latency(freeze=%0d): got %0d want %0d", freeze, b_at, exp_b); end
  endtask

  task automatic test_raw_stall();
    run_raw(1'b0, 4, 5);
    do_reset();
    out_ready = 1'b1; inst_in = mk(1'b0, 1'b1, 3'd1, 3'd2, 3'd3); in_valid = 1'b1;
    step();
    inst_in = mk(1'b0, 1'b1, 3'd4, 3'd0, 3'd6);
    #1;
    checks++;
    if ({hazard_out, in_ready} !== 2'b01)
      begin errors++; $display("FAIL raw_no_dep: got hazard/ready %b want 01", {hazard_out, in_ready}); end
    step();
    in_valid = 1'b0;
    checks++;
    if (obs !== exp_out(1'b1, mk(1'b0, 1'b1, 3'd4, 3'd0, 3'd6)))
      begin errors++; $display("FAIL raw_no_dep_fields: got %h", obs); end
  endtask

  task automatic test_en_freeze();
    run_raw(1'b1, 6, 7);
  endtask

  task automatic test_flush();
    logic [31:0] b;
    b = mk(1'b0, 1'b1, 3'd3, 3'd0, 3'd6);
    do_reset();
    inst_in = mk(1'b0, 1'b1, 3'd1, 3'd2, 3'd3); in_valid = 1'b1;
    step();
    inst_in = b;
    #1;
    checks++;
    if (hazard_out !== 1'b1) begin errors++; $display("FAIL flush_pre_hazard: got %b want 1", hazard_out); end
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    #1;
    checks++;
    if ({hazard_out, in_ready} !== 2'b01)
      begin errors++; $display("FAIL flush_untracked: got hazard/ready %b want 01", {hazard_out, in_ready}); end
    step();
    in_valid = 1'b0;
    checks++;
    if (obs !== exp_out(1'b1, b)) begin errors++; $display("FAIL flush_next_fields: got %h want %h", obs, exp_out(1'b1, b)); end
  endtask

  task automatic test_reset_mid_stall();
    logic [31:0] b;
    b = mk(1'b0, 1'b1, 3'd3, 3'd0, 3'd6);
    do_reset();
    out_ready = 1'b1; inst_in = mk(1'b0, 1'b1, 3'd1, 3'd2, 3'd3); in_valid = 1'b1;
    step();
    inst_in = b;
    step();
    step();
    checks++;
    if (hazard_out !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_hazard: got %b want 1", hazard_out); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (obs !== 12'h000) begin errors++; $display("FAIL rst_mid_outputs: got %h want 000", obs); end
    #1;
    checks++;
    if ({hazard_out, in_ready} !== 2'b01)
      begin errors++; $display("FAIL rst_mid_hazard_ready: got %b want 01", {hazard_out, in_ready}); end
    step();
    in_valid = 1'b0;
    checks++;
    if (obs !== exp_out(1'b1, b)) begin errors++; $display("FAIL rst_mid_accept: got %h want %h", obs, exp_out(1'b1, b)); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_backpressure();
    test_raw_stall();
    test_en_freeze();
    test_flush();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
